// File: rtl/pingpong_table_container.sv
// Two-bank lookup table: a new table streams into the shadow bank while two read ports use the
// active bank, and a commit swaps the banks atomically. Optional macro: PINGPONG_TABLE_CLAMP_EN.
module pingpong_table_container #(
    parameter int C_DATA_WIDTH    = 8,
    parameter int C_ADDRESS_WIDTH = 8,
    parameter int C_RD_LATENCY    = 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ld_start,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [C_DATA_WIDTH-1:0]    s_data,
    input  logic                       s_last,
    input  logic                       commit,
    output logic                       ld_done,
    output logic                       truncated,
    output logic                       active_bank,
    output logic [C_ADDRESS_WIDTH:0]   size,
    input  logic [C_ADDRESS_WIDTH-1:0] addrA,
    output logic [C_DATA_WIDTH-1:0]    qA,
    input  logic [C_ADDRESS_WIDTH-1:0] addrB,
    output logic [C_DATA_WIDTH-1:0]    qB
);

    localparam int DEPTH = 1 << C_ADDRESS_WIDTH;
    localparam logic [C_ADDRESS_WIDTH:0] LAST_IDX = (C_ADDRESS_WIDTH+1)'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                   state;
    logic [C_ADDRESS_WIDTH:0] count;
    logic [C_DATA_WIDTH-1:0]  mem [2*DEPTH];
    logic                     wr_en;
    logic [C_DATA_WIDTH-1:0]  rd_a, rd_b;
    logic [C_DATA_WIDTH-1:0]  qa_p0, qb_p0;

    // A restart pulse wins over a beat offered in the same cycle.
    assign wr_en = (state == LOAD) && s_valid && !ld_start;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            count       <= '0;
            s_ready     <= 1'b0;
            ld_done     <= 1'b0;
            truncated   <= 1'b0;
            active_bank <= 1'b0;
            size        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_start) begin
                        state     <= LOAD;
                        count     <= '0;
                        truncated <= 1'b0;
                        s_ready   <= 1'b1;
                    end
                end
                LOAD: begin
                    if (ld_start) begin
                        count     <= '0;
                        truncated <= 1'b0;
                    end else if (s_valid) begin
                        count <= count + 1'b1;
                        if (s_last || count == LAST_IDX) begin
                            state     <= DONE;
                            s_ready   <= 1'b0;
                            ld_done   <= 1'b1;
                            truncated <= !s_last;
                        end
                    end
                end
                DONE: begin
                    if (commit) begin
                        active_bank <= ~active_bank;
                        size        <= count;
                        ld_done     <= 1'b0;
                    end
                    // With a simultaneous commit the restart targets the freshly retired bank.
                    if (ld_start) begin
                        state     <= LOAD;
                        count     <= '0;
                        truncated <= 1'b0;
                        s_ready   <= 1'b1;
                        ld_done   <= 1'b0;
                    end else if (commit) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    s_ready <= 1'b0;
                    ld_done <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[{~active_bank, count[C_ADDRESS_WIDTH-1:0]}] <= s_data;
    end

`ifdef PINGPONG_TABLE_CLAMP_EN
    function automatic logic [C_ADDRESS_WIDTH-1:0] clamp_addr(
        input logic [C_ADDRESS_WIDTH-1:0] addr,
        input logic [C_ADDRESS_WIDTH:0]   sz
    );
        if ({1'b0, addr} >= sz) return C_ADDRESS_WIDTH'(sz - 1'b1);
        return addr;
    endfunction

    assign rd_a = (size == '0) ? '0 : mem[{active_bank, clamp_addr(addrA, size)}];
    assign rd_b = (size == '0) ? '0 : mem[{active_bank, clamp_addr(addrB, size)}];
`else
    assign rd_a = mem[{active_bank, addrA}];
    assign rd_b = mem[{active_bank, addrB}];
`endif

    // Stage p0: memory read register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            qa_p0 <= '0;
            qb_p0 <= '0;
        end else begin
            qa_p0 <= rd_a;
            qb_p0 <= rd_b;
        end
    end

    generate
        if (C_RD_LATENCY == 2) begin : g_lat2
            logic [C_DATA_WIDTH-1:0] qa_p1, qb_p1;
            // Stage p1: optional output register
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    qa_p1 <= '0;
                    qb_p1 <= '0;
                end else begin
                    qa_p1 <= qa_p0;
                    qb_p1 <= qb_p0;
                end
            end
            assign qA = qa_p1;
            assign qB = qb_p1;
        end else begin : g_lat1
            assign qA = qa_p0;
            assign qB = qb_p0;
        end
    endgenerate

endmodule

// File: tb/tb_pingpong_table_container.sv
// Self-checking bench for pingpong_table_container: directed scenarios plus random traffic
// compared every cycle against a table-level reference model.
module tb_pingpong_table_container;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int LAT   = 1;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          resetn;
    logic          ld_start, s_valid, s_ready, s_last, commit;
    logic          ld_done, truncated, active_bank;
    logic [DW-1:0] s_data, qA, qB;
    logic [AW:0]   size;
    logic [AW-1:0] addrA, addrB;

    always #5 clk = ~clk;

    pingpong_table_container #(
        .C_DATA_WIDTH(DW), .C_ADDRESS_WIDTH(AW), .C_RD_LATENCY(LAT)
    ) dut (
        .clk(clk), .resetn(resetn), .ld_start(ld_start), .s_valid(s_valid),
        .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .commit(commit),
        .ld_done(ld_done), .truncated(truncated), .active_bank(active_bank),
        .size(size), .addrA(addrA), .qA(qA), .addrB(addrB), .qB(qB)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: two tables of entries (-1 = never written), which one is read,
    // how many entries it holds, and the progress of the table being loaded.
    int mmem [2][DEPTH];
    int m_active, m_size, m_fill, m_trunc;
    bit m_loading, m_complete;
    int expa_q[$], expb_q[$];

    int full_tbl [DEPTH];
    int tA [4];
    int tB [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_read(input int a);
`ifdef PINGPONG_TABLE_CLAMP_EN
        if (m_size == 0) return 0;
        if (a >= m_size) a = m_size - 1;
`endif
        return mmem[m_active][a];
    endfunction

    task automatic model_reset();
        m_active = 0; m_size = 0; m_fill = 0; m_trunc = 0;
        m_loading = 0; m_complete = 0;
        expa_q.delete(); expb_q.delete();
        repeat (LAT - 1) begin
            expa_q.push_back(0);
            expb_q.push_back(0);
        end
    endtask

    task automatic begin_load();
        m_loading = 1; m_complete = 0; m_fill = 0; m_trunc = 0;
    endtask

    task automatic model_update();
        if (m_complete && commit) begin
            m_active = 1 - m_active;
            m_size   = m_fill;
            m_complete = 0;
            if (!ld_start) return;
        end
        if (ld_start) begin
            begin_load();
        end else if (m_loading && s_valid) begin
            mmem[1 - m_active][m_fill] = int'(s_data);
            m_fill++;
            if (s_last || m_fill == DEPTH) begin
                m_loading  = 0;
                m_complete = 1;
                m_trunc    = (!s_last) ? 1 : 0;
            end
        end
    endtask

    task automatic step();
        int ea, eb;
        expa_q.push_back(exp_read(int'(addrA)));
        expb_q.push_back(exp_read(int'(addrB)));
        @(posedge clk);
        #1;
        model_update();
        ea = expa_q.pop_front();
        eb = expb_q.pop_front();
        if (ea >= 0) chk("qA", qA, ea);
        if (eb >= 0) chk("qB", qB, eb);
        chk("s_ready", s_ready, m_loading);
        chk("ld_done", ld_done, m_complete);
        chk("truncated", truncated, m_trunc);
        chk("active_bank", active_bank, m_active);
        chk("size", size, m_size);
    endtask

    task automatic pulse_start();
        ld_start = 1'b1; step(); ld_start = 1'b0;
    endtask

    task automatic beat(input int d, input bit last);
        s_valid = 1'b1; s_data = DW'(d); s_last = last;
        step();
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1; step(); commit = 1'b0;
    endtask

    task automatic read_ab(input int a, input int b);
        addrA = AW'(a); addrB = AW'(b);
        repeat (LAT) step();
    endtask

    initial begin
        foreach (mmem[i, j]) mmem[i][j] = -1;
        resetn = 1'b0; ld_start = 0; s_valid = 0; s_last = 0; commit = 0;
        s_data = '0; addrA = '0; addrB = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_ld_done", ld_done, 0);
        chk("rst_truncated", truncated, 0);
        chk("rst_active_bank", active_bank, 0);
        chk("rst_size", size, 0);
        chk("rst_qA", qA, 0);
        chk("rst_qB", qB, 0);
        resetn = 1'b1;

        // Basic 4-entry table
        pulse_start();
        for (int i = 0; i < 4; i++) beat(8'h10 + i, i == 3);
        chk("t1_ld_done", ld_done, 1);
        step();
        chk("t1_ld_done_hold", ld_done, 1);
        do_commit();
        chk("t1_active", active_bank, 1);
        chk("t1_size", size, 4);
        read_ab(2, 0);
        chk("t1_qA", qA, 8'h12);
        chk("t1_qB", qB, 8'h10);

        // Full-depth load without s_last
        pulse_start();
        for (int i = 0; i < DEPTH; i++) begin
            full_tbl[i] = int'($urandom_range(255));
            beat(full_tbl[i], 1'b0);
        end
        chk("full_truncated", truncated, 1);
        chk("full_s_ready", s_ready, 0);
        chk("full_ld_done", ld_done, 1);
        beat(8'hEE, 1'b0);
        do_commit();
        chk("full_size", size, 256);
        chk("full_active", active_bank, 0);
        read_ab(255, 0);
        chk("full_q255", qA, full_tbl[255]);
        chk("full_q0", qB, full_tbl[0]);

        // Table A active while table B streams in; reads must switch cleanly
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            tA[i] = int'($urandom_range(255));
            beat(tA[i], i == 3);
        end
        do_commit();
        chk("ab_size", size, 4);
        pulse_start();
        for (int i = 0; i < 4; i++) tB[i] = int'($urandom_range(255));
        for (int c = 0; c < 16; c++) begin
            addrA = AW'(c % 4);
            addrB = AW'(3 - (c % 4));
            s_valid = (c < 4);
            s_data  = (c < 4) ? DW'(tB[c]) : '0;
            s_last  = (c == 3);
            commit  = (c == 6);
            step();
            if (c == 5) chk("ab_qA_before", qA, tA[(c - LAT + 1) % 4]);
        end
        s_valid = 0; s_last = 0; commit = 0;
        read_ab(1, 2);
        chk("ab_qA_after", qA, tB[1]);
        chk("ab_qB_after", qB, tB[2]);

        // Out-of-range address with a 4-entry table
        read_ab(200, 3);
`ifdef PINGPONG_TABLE_CLAMP_EN
        chk("oob_qA", qA, tB[3]);
`else
        chk("oob_qA", qA, full_tbl[200]);
`endif

        // Stray commits and restart mid-load
        do_commit();
        chk("idle_commit_active", active_bank, 0);
        chk("idle_commit_size", size, 4);
        pulse_start();
        for (int i = 0; i < 3; i++) beat(8'h50 + i, 1'b0);
        do_commit();
        chk("load_commit_active", active_bank, 0);
        chk("load_commit_size", size, 4);
        ld_start = 1'b1; s_valid = 1'b1; s_data = 8'h77; step();
        ld_start = 1'b0; s_valid = 1'b0;
        beat(8'hA5, 1'b0);
        beat(8'hA6, 1'b1);
        do_commit();
        chk("restart_size", size, 2);
        read_ab(0, 1);
        chk("restart_q0", qA, 8'hA5);
        chk("restart_q1", qB, 8'hA6);

        // Commit and ld_start together in DONE
        pulse_start();
        beat(8'h3C, 1'b1);
        ld_start = 1'b1; commit = 1'b1; step();
        ld_start = 1'b0; commit = 1'b0;
        chk("both_active", active_bank, 0);
        chk("both_size", size, 1);
        chk("both_s_ready", s_ready, 1);
        beat(8'hC3, 1'b1);
        do_commit();
        read_ab(0, 0);
        chk("both_q0", qA, 8'hC3);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            ld_start = (!m_loading && !m_complete) ? ($urandom_range(3) == 0)
                                                   : ($urandom_range(60) == 0);
            commit  = ($urandom_range(5) == 0);
            s_valid = ($urandom_range(2) != 0);
            s_last  = ($urandom_range(9) == 0);
            s_data  = DW'($urandom_range(255));
            addrA   = AW'($urandom_range(DEPTH - 1));
            addrB   = (m_size > 0) ? AW'($urandom_range(m_size - 1)) : '0;
            step();
        end
        ld_start = 0; commit = 0; s_valid = 0; s_last = 0;

        // Asynchronous reset in the middle of a load, with bank 1 active
        for (int k = 0; k < 2 && m_active == 0; k++) begin
            pulse_start();
            beat(8'h99, 1'b1);
            do_commit();
        end
        chk("pre_rst_active", active_bank, 1);
        pulse_start();
        for (int i = 0; i < 5; i++) beat(8'h60 + i, 1'b0);
        #2 resetn = 1'b0;
        #1;
        chk("arst_s_ready", s_ready, 0);
        chk("arst_ld_done", ld_done, 0);
        chk("arst_size", size, 0);
        chk("arst_active", active_bank, 0);
        chk("arst_qA", qA, 0);
        model_reset();
        #1 resetn = 1'b1;
        step();
        chk("post_rst_idle", s_ready, 0);
        do_commit();
        chk("post_rst_commit_active", active_bank, 0);
        chk("post_rst_commit_size", size, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pingpong_table_container.md
Name: pingpong_table_container

Overview:
- Two-bank lookup table with a sequential loader and two independent random-access read ports.
- A new table streams into the shadow bank under valid/ready while readers keep using the active bank undisturbed. A commit pulse swaps the banks atomically.
- Sits between the CPU/DMA table source and pixel-rate consumers that need glitch-free table updates, such as gamma or remap LUTs.

Parameters:
- C_DATA_WIDTH, 8, table entry width in bits.
- C_ADDRESS_WIDTH, 8, bank depth is 2**C_ADDRESS_WIDTH entries.
- C_RD_LATENCY, 1, read latency in cycles; legal values are 1 or 2. Value 2 adds an output register stage.

Ports:
- clk  in  1  single clock for all logic
- resetn  in  1  asynchronous active-low reset
- ld_start  in  1  pulse: begin loading a new table into the shadow bank
- s_valid  in  1  load beat valid
- s_ready  out  1  load beat accepted when s_valid & s_ready
- s_data  in  C_DATA_WIDTH  load beat data
- s_last  in  1  final beat of the table
- commit  in  1  pulse: swap banks if a load is complete
- ld_done  out  1  shadow bank holds a complete table awaiting commit
- truncated  out  1  last load hit full depth without s_last
- active_bank  out  1  index of the bank being read
- size  out  C_ADDRESS_WIDTH+1  number of valid entries in the active bank
- addrA  in  C_ADDRESS_WIDTH  read port A address
- qA  out  C_DATA_WIDTH  read port A data
- addrB  in  C_ADDRESS_WIDTH  read port B address
- qB  out  C_DATA_WIDTH  read port B data

Behaviour:
- Reset values: s_ready=0, ld_done=0, truncated=0, active_bank=0, size=0, qA=qB=0, FSM=IDLE, fill count=0. Memory contents are not reset.
- FSM states: IDLE, LOAD, DONE.
- IDLE: s_ready=0. ld_start -> LOAD, fill count=0, truncated=0.
- LOAD: s_ready=1. Each accepted beat writes s_data to shadow[count], then count+1.
  - Accepted beat with s_last=1 -> DONE.
  - Accepted beat when count==2**AW-1 and s_last=0 -> DONE, truncated=1. s_ready drops the next cycle.
  - Beats offered after that are not accepted.
  - count is AW+1 bits wide and reaches 2**AW at full depth.
- DONE: s_ready=0, ld_done=1. commit -> active_bank toggles, size<=count, ld_done=0, next state IDLE.
- commit outside DONE: ignored, no state change.
- ld_start in LOAD or DONE: restarts the load into the same shadow bank. count=0, ld_done=0, truncated=0, next state LOAD. The beat offered in that cycle is not accepted.
- ld_start and commit in the same cycle while in DONE: the commit wins first. Banks swap and size updates, then the FSM goes to LOAD on the new shadow bank (the old active bank).
- Empty table: ld_start then commit without any beats cannot complete, because DONE requires at least one beat. size never commits to 0 after reset.
- Reads: qA/qB = active[addr] sampled at the clock edge, presented C_RD_LATENCY cycles later.
  - The bank is selected by the active_bank value in the sampling cycle. A commit in cycle N affects addresses sampled from cycle N+1.
  - Both ports may read the same address at once.
  - Writes never target the active bank, so there is no read/write collision.
- Reset mid-load: the FSM returns to IDLE and active_bank returns to 0. Table contents are retained but size=0 marks them invalid.

Optional Feature:
- Macro: PINGPONG_TABLE_CLAMP_EN.
- Defined: a read address >= size is replaced by size-1 before the memory access.
- Defined, size==0: qA/qB return 0.
- Undefined: addresses are used raw, so stale or uninitialised data may be returned.

Test Plan:
- Reset, then ld_start and 4 beats 0x10..0x13 with s_last on the 4th, then commit. Required: ld_done high for 1+ cycles, active_bank=1, size=4. addrA=2 gives qA=0x12 after C_RD_LATENCY cycles; addrB=0 gives qB=0x10 on the same cycle.
- Load a full 256 beats without s_last (AW=8). Required: DONE entered, truncated=1, s_ready=0 afterwards. After commit, size=256 and addr 255 returns the 256th beat.
- Table A committed (size 4), table B loading continuously while addrA sweeps 0..3. Required: qA shows only table A until the cycle after commit, then table B values with no mixed or garbage cycle.
- commit pulsed in IDLE and LOAD. Required: active_bank and size unchanged. ld_start during LOAD at count=3 gives count=0, and the next beat lands at address 0.
- resetn asserted low mid-load (count=5) for one cycle. Required: s_ready, ld_done and size go to 0 immediately (asynchronously), active_bank=0, FSM=IDLE.
- With PINGPONG_TABLE_CLAMP_EN and size=4: addrA=200 gives qA=entry[3]. Without the macro: addrA=200 gives the raw memory word.
